// File: rtl/ps2_mouse_receiver.sv
// PS/2 device-to-host byte receiver. BYTE_READY pulses one cycle after the stop-bit edge.
// There is no backpressure: READ_ENABLE low aborts or blocks frames, and each byte is reported once.
module ps2_mouse_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t          state;
    logic            clk_meta;
    logic            clk_sync;
    logic            clk_prev;
    logic            data_meta;
    logic            data_sync;
    logic [2:0]      bit_cnt;
    logic [TW-1:0]   timeout_cnt;
    logic [7:0]      shift_reg;
    logic            parity_err;
    logic            fall;

    assign fall = clk_prev & ~clk_sync;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= IDLE;
            clk_meta        <= 1'b1;
            clk_sync        <= 1'b1;
            clk_prev        <= 1'b1;
            data_meta       <= 1'b1;
            data_sync       <= 1'b1;
            bit_cnt         <= '0;
            timeout_cnt     <= '0;
            shift_reg       <= 8'h00;
            parity_err      <= 1'b0;
            BYTE_READ       <= 8'h00;
            BYTE_ERROR_CODE <= 2'b00;
            BYTE_READY      <= 1'b0;
        end else begin
            clk_meta   <= CLK_MOUSE_IN;
            clk_sync   <= clk_meta;
            clk_prev   <= clk_sync;
            data_meta  <= DATA_MOUSE_IN;
            data_sync  <= data_meta;
            BYTE_READY <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall && READ_ENABLE && !data_sync) begin
                        state       <= DATA;
                        bit_cnt     <= '0;
                        timeout_cnt <= '0;
                    end
                end
                DATA, PARITY, STOP: begin
                    // Abort beats a coincident edge; an edge beats a coincident timeout.
                    if (!READ_ENABLE) begin
                        state <= IDLE;
                    end else if (fall) begin
                        timeout_cnt <= '0;
                        case (state)
                            DATA: begin
                                shift_reg[bit_cnt] <= data_sync;
                                if (bit_cnt == 3'd7) begin
                                    state <= PARITY;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                            PARITY: begin
                                parity_err <= ~(^shift_reg ^ data_sync);
                                state      <= STOP;
                            end
                            default: begin
                                // Outputs are loaded on entry to DONE so they are valid with the pulse.
                                BYTE_READ       <= shift_reg;
                                BYTE_ERROR_CODE <= {~data_sync, parity_err};
                                BYTE_READY      <= 1'b1;
                                state           <= DONE;
                            end
                        endcase
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// Directed bench for ps2_mouse_receiver with a shortened timeout.
module tb_ps2_mouse_receiver;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       read_enable = 1'b1;
    logic [7:0] byte_read;
    logic [1:0] byte_error_code;
    logic       byte_ready;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    ps2_mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(clk),
        .RESET(reset),
        .CLK_MOUSE_IN(ps2_clk),
        .DATA_MOUSE_IN(ps2_data),
        .READ_ENABLE(read_enable),
        .BYTE_READ(byte_read),
        .BYTE_ERROR_CODE(byte_error_code),
        .BYTE_READY(byte_ready)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (byte_ready) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set up while the line clock is high, then a low phase.
    task automatic ps2_bit(input logic b, input logic lat);
        @(negedge clk);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        if (lat) begin
            repeat (2) begin
                @(posedge clk);
                #1 check("lat_early", {31'd0, byte_ready}, 32'd0);
            end
            @(posedge clk);
            #1 check("lat_pulse", {31'd0, byte_ready}, 32'd1);
            @(posedge clk);
            #1 check("lat_single", {31'd0, byte_ready}, 32'd0);
            repeat (17) @(negedge clk);
        end else begin
            repeat (20) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input int first, input int last);
        for (int i = first; i <= last; i++) ps2_bit(d[i], 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input logic lat);
        ps2_bit(1'b0, 1'b0);
        send_bits(d, 0, 7);
        ps2_bit(par, 1'b0);
        ps2_bit(stp, lat);
        repeat (20) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int pulses, input logic [7:0] b, input logic [1:0] code);
        check({tag, "_pulses"}, pulse_cnt, pulses);
        check({tag, "_byte"}, {24'd0, byte_read}, {24'd0, b});
        check({tag, "_code"}, {30'd0, byte_error_code}, {30'd0, code});
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("reset_byte", {24'd0, byte_read}, 32'h00);
        check("reset_code", {30'd0, byte_error_code}, 32'h0);
        check("reset_ready", {31'd0, byte_ready}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(8'hFA, 1'b1, 1'b1, 1'b1);
        check_result("fa", 1, 8'hFA, 2'b00);

        send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
        check_result("aa_parity", 2, 8'hAA, 2'b01);

        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        check_result("zero_stop", 3, 8'h00, 2'b10);

        // A falling edge with data high is not a start bit.
        ps2_bit(1'b1, 1'b0);
        send_bits(8'hFF, 0, 7);
        ps2_bit(1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("bad_start_pulses", pulse_cnt, 3);

        // Start plus four data bits, then silence past the timeout.
        ps2_bit(1'b0, 1'b0);
        send_bits(8'hF4, 0, 3);
        repeat (TO + 50) @(negedge clk);
        check_result("timeout", 3, 8'h00, 2'b10);
        send_frame(8'hF4, 1'b0, 1'b1, 1'b0);
        check_result("f4", 4, 8'hF4, 2'b00);

        read_enable = 1'b0;
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        check_result("disabled", 4, 8'hF4, 2'b00);

        // Brief READ_ENABLE drop after bit 3 must kill the frame.
        read_enable = 1'b1;
        ps2_bit(1'b0, 1'b0);
        send_bits(8'h55, 0, 3);
        read_enable = 1'b0;
        repeat (3) @(negedge clk);
        read_enable = 1'b1;
        send_bits(8'h55, 4, 7);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        repeat (TO + 50) @(negedge clk);
        check_result("abort", 4, 8'hF4, 2'b00);

        ps2_bit(1'b0, 1'b0);
        send_bits(8'h12, 0, 5);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_byte", {24'd0, byte_read}, 32'h00);
        check("midreset_ready", {31'd0, byte_ready}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h34, 1'b0, 1'b1, 1'b0);
        check_result("after_reset", 5, 8'h34, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
